video_timing_recover: RTL and testbench

- Receive-side counterpart of the video timing generator: takes hsync/vsync/hbl/vbl from an upstream source, qualified by the pixel enable.
- Recovers the pixel/line position (hc/vc) and measures the frame geometry.
- Reports a locked status once the geometry has been stable for several frames.
- Sits between the core's video output and the scaler/OSD path, which needs the geometry and position without sharing the generator's counters.

---
 rtl/video_timing_recover.sv | 193 +++++++++++++++++++
 tb/tb_video_timing_recover.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_recover.sv
// video_timing_recover: rebuilds pixel/line position from an incoming sync/blank
// stream, measures the frame geometry and reports lock once it stays stable.
module video_timing_recover #(
  parameter int unsigned HW          = 10,
  parameter int unsigned VW          = 10,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_pix,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hbl,
  input  logic          vbl,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc,
  output logic [HW-1:0] htotal,
  output logic [HW-1:0] hactive,
  output logic [HW-1:0] hs_start,
  output logic [HW-1:0] hs_width,
  output logic [VW-1:0] vtotal,
  output logic [VW-1:0] vactive,
  output logic          frame_start,
  output logic          locked,
  output logic          timeout
);

  localparam int unsigned   CW     = 4;
  localparam logic [HW-1:0] H_MAX  = '1;
  localparam logic [VW-1:0] V_MAX  = '1;
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] match_cnt;

  logic          hsync_q, vsync_q, hbl_q, vbl_q;
  logic [HW-1:0] line_len, act_w, hs_pos, hs_w;
  logic [VW-1:0] frame_len, act_h;

  logic          hbl_rise, hbl_fall, hsync_rise, hsync_fall, vbl_rise, vbl_fall;
  logic [HW-1:0] hc_inc, hc_n, line_len_n, act_w_n, hs_pos_n, hs_w_n;
  logic [VW-1:0] vc_inc, vc_n, frame_len_n, act_h_n;
  logic          h_to, v_to, geom_diff;
  logic [CW-1:0] match_inc;
  logic          vsync_unused;

  // vsync only feeds its edge register; nothing downstream consumes it
  assign vsync_unused = vsync_q;

  // Edges, next counter values and the captures this enable would produce
  always_comb begin
    hbl_rise   = hbl & ~hbl_q;
    hbl_fall   = ~hbl & hbl_q;
    hsync_rise = hsync & ~hsync_q;
    hsync_fall = ~hsync & hsync_q;
    vbl_rise   = vbl & ~vbl_q;
    vbl_fall   = ~vbl & vbl_q;

    hc_inc     = hc + HW'(1);
    hc_n       = hbl_fall ? '0 : ((hc == H_MAX) ? H_MAX : hc_inc);
    line_len_n = hbl_fall ? hc_inc : line_len;
    act_w_n    = hbl_rise ? hc_inc : act_w;
    hs_pos_n   = hsync_rise ? hc_inc : hs_pos;
    hs_w_n     = hsync_fall ? (hc_inc - hs_pos) : hs_w;

    vc_inc = vc + VW'(1);
    vc_n   = vc;
    if (vbl_fall) begin
      vc_n = '0;
    end else if (hbl_fall) begin
      vc_n = (vc == V_MAX) ? V_MAX : vc_inc;
    end
    frame_len_n = vbl_fall ? vc_inc : frame_len;
    act_h_n     = vbl_rise ? vc_n : act_h;

    // Loss of sync: a counter runs into saturation instead of being restarted
    h_to = (hc != H_MAX) && (hc_n == H_MAX);
    v_to = (vc != V_MAX) && (vc_n == V_MAX);

    geom_diff = (line_len_n != htotal) || (act_w_n != hactive) ||
                (hs_pos_n != hs_start) || (hs_w_n != hs_width) ||
                (frame_len_n != vtotal) || (act_h_n != vactive);
    match_inc = match_cnt + CW'(1);
  end

  // Edge registers, position counters and working captures
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hbl_q     <= 1'b0;
      vbl_q     <= 1'b0;
      hc        <= '0;
      vc        <= '0;
      line_len  <= '0;
      act_w     <= '0;
      hs_pos    <= '0;
      hs_w      <= '0;
      frame_len <= '0;
      act_h     <= '0;
    end else if (clk_pix) begin
      hsync_q   <= hsync;
      vsync_q   <= vsync;
      hbl_q     <= hbl;
      vbl_q     <= vbl;
      hc        <= hc_n;
      vc        <= vc_n;
      line_len  <= line_len_n;
      act_w     <= act_w_n;
      hs_pos    <= hs_pos_n;
      hs_w      <= hs_w_n;
      frame_len <= frame_len_n;
      act_h     <= act_h_n;
    end
  end

  // Lock state machine, geometry publication and one-clk status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      match_cnt   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      timeout     <= 1'b0;
      htotal      <= '0;
      hactive     <= '0;
      hs_start    <= '0;
      hs_width    <= '0;
      vtotal      <= '0;
      vactive     <= '0;
    end else begin
      frame_start <= clk_pix & vbl_fall;
      timeout     <= 1'b0;
      if (clk_pix) begin
        if (h_to || v_to) begin
          timeout   <= 1'b1;
          state     <= SEARCH;
          match_cnt <= '0;
          locked    <= 1'b0;
          htotal    <= '0;
          hactive   <= '0;
          hs_start  <= '0;
          hs_width  <= '0;
          vtotal    <= '0;
          vactive   <= '0;
        end else if (vbl_fall) begin
          htotal   <= line_len_n;
          hactive  <= act_w_n;
          hs_start <= hs_pos_n;
          hs_width <= hs_w_n;
          vtotal   <= frame_len_n;
          vactive  <= act_h_n;
          case (state)
            SEARCH: begin
              state     <= MEASURE;
              match_cnt <= '0;
            end
            MEASURE: begin
              if (geom_diff) begin
                match_cnt <= '0;
              end else begin
                match_cnt <= match_inc;
                if (match_inc == LOCK_N) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
            LOCKED: begin
              if (geom_diff) begin
                state     <= MEASURE;
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end
            default: begin
              state     <= SEARCH;
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_recover.sv
// Bench for video_timing_recover: streams frames built from a geometry record and
// checks every clk against a frame-level model of position, geometry and lock.
module tb_video_timing_recover;

  localparam int unsigned HW          = 10;
  localparam int unsigned VW          = 10;
  localparam int unsigned LOCK_FRAMES = 2;
  localparam int          HMAX        = (1 << HW) - 1;
  localparam int          VMAX        = (1 << VW) - 1;

  logic          clk = 1'b0;
  logic          reset, clk_pix, hsync, vsync, hbl, vbl;
  logic [HW-1:0] hc, htotal, hactive, hs_start, hs_width;
  logic [VW-1:0] vc, vtotal, vactive;
  logic          frame_start, locked, timeout;

  video_timing_recover #(
    .HW(HW), .VW(VW), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .clk_pix(clk_pix),
    .hsync(hsync), .vsync(vsync), .hbl(hbl), .vbl(vbl),
    .hc(hc), .vc(vc), .htotal(htotal), .hactive(hactive),
    .hs_start(hs_start), .hs_width(hs_width), .vtotal(vtotal), .vactive(vactive),
    .frame_start(frame_start), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int htot; int hact; int hss; int hsw; int vtot; int vact;
  } geom_t;

  int    errors = 0;
  int    checks = 0;
  int    en_period;
  // model state
  int    hc_m, vc_m, match_m;
  bit    fs_m, to_m, lk_m, search_m, pub_known_m;
  geom_t pub_m, last_g;
  bit    last_known, cur_known, prev_hbl, prev_vbl;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit geom_eq(input geom_t a, input geom_t b);
    return a.htot == b.htot && a.hact == b.hact && a.hss == b.hss &&
           a.hsw == b.hsw && a.vtot == b.vtot && a.vact == b.vact;
  endfunction

  function automatic geom_t zero_geom();
    geom_t g;
    g = '{htot: 0, hact: 0, hss: 0, hsw: 0, vtot: 0, vact: 0};
    return g;
  endfunction

  function automatic geom_t rand_geom();
    geom_t g;
    g.htot = int'($urandom_range(48, 24));
    g.hact = int'($urandom_range(g.htot - 12, 8));
    g.hss  = g.hact + int'($urandom_range(3, 1));
    g.hsw  = int'($urandom_range(g.htot - 1 - g.hss, 1));
    g.vtot = int'($urandom_range(12, 6));
    g.vact = int'($urandom_range(g.vtot - 2, 2));
    return g;
  endfunction

  task automatic model_reset();
    hc_m = 0; vc_m = 0; match_m = 0;
    fs_m = 0; to_m = 0; lk_m = 0; search_m = 1;
    pub_m = zero_geom(); pub_known_m = 1;
    prev_hbl = 0; prev_vbl = 0;
  endtask

  // A frame of geometry g (known = captured cleanly) just ended
  task automatic frame_done(input geom_t g, input bit known);
    if (search_m) begin
      search_m = 0;
      match_m  = 0;
    end else if (known && pub_known_m && geom_eq(g, pub_m)) begin
      if (!lk_m) begin
        match_m++;
        if (match_m >= int'(LOCK_FRAMES)) lk_m = 1;
      end
    end else begin
      match_m = 0;
      lk_m    = 0;
    end
    pub_m       = g;
    pub_known_m = known;
  endtask

  task automatic model_enable(input bit hb, input bit vb);
    bit line_start, frame_ev;
    int old_hc, old_vc;
    line_start = prev_hbl && !hb;
    frame_ev   = prev_vbl && !vb;
    old_hc = hc_m;
    old_vc = vc_m;
    hc_m = line_start ? 0 : ((hc_m == HMAX) ? HMAX : hc_m + 1);
    if (frame_ev) vc_m = 0;
    else if (line_start && vc_m != VMAX) vc_m = vc_m + 1;
    to_m = (hc_m == HMAX && old_hc != HMAX) || (vc_m == VMAX && old_vc != VMAX);
    fs_m = frame_ev;
    if (to_m) begin
      search_m = 1; lk_m = 0; match_m = 0;
      pub_m = zero_geom(); pub_known_m = 1;
    end else if (frame_ev) begin
      frame_done(last_g, last_known);
    end
    prev_hbl = hb;
    prev_vbl = vb;
  endtask

  task automatic check_all();
    check("hc", 32'(hc), hc_m);
    check("vc", 32'(vc), vc_m);
    if (pub_known_m) begin
      check("htotal", 32'(htotal), pub_m.htot);
      check("hactive", 32'(hactive), pub_m.hact);
      check("hs_start", 32'(hs_start), pub_m.hss);
      check("hs_width", 32'(hs_width), pub_m.hsw);
      check("vtotal", 32'(vtotal), pub_m.vtot);
      check("vactive", 32'(vactive), pub_m.vact);
    end
    check("frame_start", 32'(frame_start), int'(fs_m));
    check("locked", 32'(locked), int'(lk_m));
    check("timeout", 32'(timeout), int'(to_m));
  endtask

  task automatic step(input bit en, input bit hs, input bit vs, input bit hb, input bit vb);
    @(negedge clk);
    clk_pix = en; hsync = hs; vsync = vs; hbl = hb; vbl = vb;
    @(posedge clk);
    #1;
    fs_m = 0;
    to_m = 0;
    if (en) model_enable(hb, vb);
    check_all();
  endtask

  task automatic emit_pixel(input bit hs, input bit vs, input bit hb, input bit vb);
    int gap;
    gap = (en_period > 0) ? en_period - 1 : int'($urandom_range(1, 0));
    for (int i = 0; i < gap; i++) step(1'b0, hs, vs, hb, vb);
    step(1'b1, hs, vs, hb, vb);
  endtask

  task automatic do_async_reset();
    @(negedge clk);
    clk_pix = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    cur_known = 0;
    check_all();
    #1 reset = 1'b0;
  endtask

  // One frame; hold stretches pixel 0 of line 0, rst_line >= 0 resets mid-line
  task automatic emit_frame(input geom_t g, input int hold, input int rst_line);
    bit hs, vs, hb, vb;
    cur_known = 1;
    for (int l = 0; l < g.vtot; l++) begin
      for (int p = 0; p < g.htot; p++) begin
        hb = (p >= g.hact);
        hs = (p >= g.hss) && (p < g.hss + g.hsw);
        vb = (l >= g.vact);
        vs = (l == g.vact + 1);
        if (l == rst_line && p == 2) do_async_reset();
        emit_pixel(hs, vs, hb, vb);
        if (l == 0 && p == 0) begin
          for (int k = 0; k < hold; k++) emit_pixel(hs, vs, hb, vb);
        end
      end
    end
    last_g     = g;
    last_known = cur_known;
  endtask

  initial begin
    geom_t g0, g1, g;
    int    n;
    reset = 1'b0; clk_pix = 1'b0;
    hsync = 1'b0; vsync = 1'b0; hbl = 1'b0; vbl = 1'b0;
    en_period = 0;
    last_known = 0; cur_known = 1;
    last_g = zero_geom();
    model_reset();

    // reset state
    #1 reset = 1'b1;
    #3;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // clean stream, one enable every 4th clk: locks on the 3rd vbl fall
    en_period = 4;
    g0 = '{htot: 64, hact: 32, hss: 42, hsw: 5, vtot: 12, vact: 9};
    repeat (4) emit_frame(g0, 0, -1);
    check("g0_locked", 32'(locked), 1);
    check("g0_vtotal", 32'(vtotal), 12);

    // one line longer per frame: drop, then relock after two more frames
    en_period = 0;
    g1 = g0;
    g1.vtot = 13;
    repeat (4) emit_frame(g1, 0, -1);
    check("g1_locked", 32'(locked), 1);
    check("g1_vtotal", 32'(vtotal), 13);

    // hbl stuck low long enough for hc to saturate, then recovery
    emit_frame(g1, 1030, -1);
    repeat (3) emit_frame(g1, 0, -1);
    check("to_relocked", 32'(locked), 1);

    // random geometries, sometimes repeated
    g = rand_geom();
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && ($urandom_range(2, 0) != 0)) g = rand_geom();
      n = int'($urandom_range(3, 1));
      for (int j = 0; j < n; j++) emit_frame(g, 0, -1);
    end

    // asynchronous reset in the middle of an active line
    g = rand_geom();
    emit_frame(g, 0, int'($urandom_range(g.vact - 1, 1)));
    repeat (4) emit_frame(g, 0, -1);
    check("rst_relocked", 32'(locked), 1);
    check("rst_htotal", 32'(htotal), g.htot);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
